seg_dynamic_scan: RTL

Six-digit multiplexed seven-segment driver that sits directly downstream of the binary-to-BCD converter. It consumes six BCD digits, a decimal-point mask and a sign flag, and time-multiplexes them onto a common-anode display: one digit is active at a time, each for a fixed scan period. It performs leading-zero blanking and minus-sign placement, and latches its inputs once per frame so a frame never mixes old and new values.

---
 rtl/seg_pkg.sv | 20 ++
 rtl/bcd_to_seg.sv | 29 ++
 rtl/seg_dynamic_scan.sv | 125 ++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the six-digit seven-segment scanner
package seg_pkg;

    localparam int NUM_DIGITS = 6;

    // Active-low patterns, bit 7 = DP (off), bits 6:0 = g..a
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_MINUS = 8'hBF;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - BCD digit to active-low seven-segment pattern
module bcd_to_seg
    import seg_pkg::*;
(
    input  logic [3:0] i_bcd,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK[6:0];
        if (!i_blank) begin
            case (i_bcd)
                4'd0:    o_seg = SEG_0[6:0];
                4'd1:    o_seg = SEG_1[6:0];
                4'd2:    o_seg = SEG_2[6:0];
                4'd3:    o_seg = SEG_3[6:0];
                4'd4:    o_seg = SEG_4[6:0];
                4'd5:    o_seg = SEG_5[6:0];
                4'd6:    o_seg = SEG_6[6:0];
                4'd7:    o_seg = SEG_7[6:0];
                4'd8:    o_seg = SEG_8[6:0];
                4'd9:    o_seg = SEG_9[6:0];
                default: o_seg = SEG_BLANK[6:0];
            endcase
        end
    end

endmodule

// File: rtl/seg_dynamic_scan.sv
// rtl/seg_dynamic_scan.sv - six-digit multiplexed display driver with
// leading-zero blanking, minus-sign placement and per-frame input latching
module seg_dynamic_scan
    import seg_pkg::*;
#(
    parameter int CNT_MAX = 49999
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       seg_en,
    input  logic [3:0] unit,
    input  logic [3:0] ten,
    input  logic [3:0] hun,
    input  logic [3:0] tho,
    input  logic [3:0] t_tho,
    input  logic [3:0] h_hun,
    input  logic [5:0] point,
    input  logic       sign,
    output logic [5:0] sel,
    output logic [7:0] seg
);

    localparam int             CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX);
    localparam logic [2:0]     SEL_LAST = 3'(NUM_DIGITS - 1);

    logic [CW-1:0]                  r_cnt_1ms;
    logic [2:0]                     r_cnt_sel;
    logic [NUM_DIGITS-1:0][3:0]     r_digit;
    logic [NUM_DIGITS-1:0]          r_point;
    logic                           r_sign;

    logic                           r_a_en;
    logic [2:0]                     r_a_idx;
    logic [6:0]                     r_a_code;
    logic                           r_a_dp;

    logic                           w_scan_end;
    logic                           w_frame_end;
    logic [2:0]                     w_top;
    logic [3:0]                     w_cur_digit;
    logic                           w_blank;
    logic                           w_minus;
    logic [6:0]                     w_dec;
    logic [6:0]                     w_code;

    assign w_scan_end  = (r_cnt_1ms == CNT_LAST);
    assign w_frame_end = w_scan_end && (r_cnt_sel == SEL_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !seg_en) begin
            r_cnt_1ms <= '0;
            r_cnt_sel <= '0;
        end else if (w_scan_end) begin
            r_cnt_1ms <= '0;
            r_cnt_sel <= (r_cnt_sel == SEL_LAST) ? 3'd0 : r_cnt_sel + 3'd1;
        end else begin
            r_cnt_1ms <= r_cnt_1ms + CW'(1);
        end
    end

    // Shadow copy refreshes only between frames so a frame never mixes values
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_digit <= '0;
            r_point <= '0;
            r_sign  <= 1'b0;
        end else if (!seg_en || w_frame_end) begin
            r_digit <= {h_hun, t_tho, tho, hun, ten, unit};
            r_point <= point;
            r_sign  <= sign;
        end
    end

    // Highest digit that must be lit: nonzero value or DP, whichever is higher
    always_comb begin
        w_top = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit[i] != 4'd0 || r_point[i]) begin
                w_top = 3'(i);
            end
        end
    end

    assign w_cur_digit = r_digit[r_cnt_sel];
    assign w_blank     = (r_cnt_sel > w_top);
    assign w_minus     = r_sign && (w_top < SEL_LAST) && (r_cnt_sel == w_top + 3'd1);

    bcd_to_seg u_bcd_to_seg (
        .i_bcd   (w_cur_digit),
        .i_blank (w_blank),
        .o_seg   (w_dec)
    );

    assign w_code = w_minus ? SEG_MINUS[6:0] : w_dec;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_a_en   <= 1'b0;
            r_a_idx  <= '0;
            r_a_code <= SEG_BLANK[6:0];
            r_a_dp   <= 1'b1;
        end else begin
            r_a_en   <= seg_en;
            r_a_idx  <= r_cnt_sel;
            r_a_code <= w_code;
            r_a_dp   <= ~r_point[r_cnt_sel];
        end
    end

    // sel and seg share one register stage so they always switch together
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sel <= 6'h3F;
            seg <= SEG_BLANK;
        end else if (r_a_en) begin
            sel <= ~(6'd1 << r_a_idx);
            seg <= {r_a_dp, r_a_code};
        end else begin
            sel <= 6'h3F;
            seg <= SEG_BLANK;
        end
    end

endmodule
